// File: rtl/midi_spi_rx.sv
// SPI-to-MIDI front end: synchronises the raw SPI pins, deserialises bytes MSB-first,
// and parses channel-voice messages (with running status) onto a valid/ready output.
module midi_spi_rx #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_SPI_sclk,
  input  logic       i_SPI_mosi,
  output logic       o_msg_valid,
  input  logic       i_msg_ready,
  output logic [7:0] o_status,
  output logic [6:0] o_data1,
  output logic [6:0] o_data2,
  output logic       o_overrun,
  output logic [1:0] byte_counter_debug
);

  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   sclk_rise;
  logic                   mosi_bit;

  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [IW-1:0] idle_cnt;
  logic          byte_done;
  logic [7:0]    byte_val;

  state_t     state, state_n;
  logic       rs_valid, rs_valid_n;
  logic [7:0] rs_byte, rs_byte_n;
  logic [6:0] d1_reg, d1_n;
  logic       emit;
  logic [6:0] emit_d1, emit_d2;

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_SPI_sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_SPI_mosi};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
    end
  end

  // Without chip-select, a long sclk silence is the only framing cue.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      idle_cnt  <= '0;
      byte_done <= 1'b0;
      byte_val  <= '0;
    end else begin
      byte_done <= 1'b0;
      if (sclk_rise) begin
        idle_cnt  <= '0;
        shift_reg <= {shift_reg[6:0], mosi_bit};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          byte_val  <= {shift_reg[6:0], mosi_bit};
        end
      end else begin
        if (idle_cnt != IW'(IDLE_TIMEOUT))
          idle_cnt <= idle_cnt + 1'b1;
        if (idle_cnt == IW'(IDLE_TIMEOUT) && bit_cnt != 3'd0) begin
          bit_cnt   <= '0;
          shift_reg <= '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= IDLE;
      rs_valid <= 1'b0;
      rs_byte  <= '0;
      d1_reg   <= '0;
    end else begin
      state    <= state_n;
      rs_valid <= rs_valid_n;
      rs_byte  <= rs_byte_n;
      d1_reg   <= d1_n;
    end
  end

  // IDLE with running status behaves exactly like WAIT_D1 for data bytes.
  always_comb begin
    state_n    = state;
    rs_valid_n = rs_valid;
    rs_byte_n  = rs_byte;
    d1_n       = d1_reg;
    emit       = 1'b0;
    emit_d1    = d1_reg;
    emit_d2    = '0;
    if (byte_done && byte_val < 8'hF8) begin
      if (byte_val[7]) begin
        if (byte_val < 8'hF0) begin
          rs_valid_n = 1'b1;
          rs_byte_n  = byte_val;
          state_n    = WAIT_D1;
        end else begin
          rs_valid_n = 1'b0;
          state_n    = IDLE;
        end
      end else begin
        unique case (state)
          IDLE, WAIT_D1: begin
            if (rs_valid) begin
              d1_n = byte_val[6:0];
              if (rs_byte[7:5] == 3'b110) begin
                emit    = 1'b1;
                emit_d1 = byte_val[6:0];
                state_n = IDLE;
              end else begin
                state_n = WAIT_D2;
              end
            end
          end
          WAIT_D2: begin
            emit    = 1'b1;
            emit_d1 = d1_reg;
            emit_d2 = byte_val[6:0];
            state_n = IDLE;
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    byte_counter_debug = 2'd0;
    unique case (state)
      WAIT_D1: byte_counter_debug = 2'd1;
      WAIT_D2: byte_counter_debug = 2'd2;
      default: byte_counter_debug = 2'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_msg_valid <= 1'b0;
      o_status    <= '0;
      o_data1     <= '0;
      o_data2     <= '0;
      o_overrun   <= 1'b0;
    end else if (emit) begin
      if (!o_msg_valid || i_msg_ready) begin
        o_msg_valid <= 1'b1;
        o_status    <= rs_byte;
        o_data1     <= emit_d1;
        o_data2     <= emit_d2;
      end else begin
        o_overrun <= 1'b1;
      end
    end else if (o_msg_valid && i_msg_ready) begin
      o_msg_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_midi_spi_rx.sv
// Directed bench for midi_spi_rx: table of byte streams with expected messages,
// plus hand-written sequences for backpressure, idle timeout and mid-byte reset.
module tb_midi_spi_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       ready = 1'b1;
  logic       valid;
  logic [7:0] status;
  logic [6:0] d1, d2;
  logic       overrun;
  logic [1:0] bcd;

  int n_cmp = 0;
  int n_err = 0;

  logic [21:0] q[$];

  midi_spi_rx #(.SYNC_STAGES(2), .IDLE_TIMEOUT(4096)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_SPI_sclk(sclk), .i_SPI_mosi(mosi),
    .o_msg_valid(valid), .i_msg_ready(ready), .o_status(status),
    .o_data1(d1), .o_data2(d2), .o_overrun(overrun), .byte_counter_debug(bcd)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && valid && ready) q.push_back({status, d1, d2});

  typedef struct {
    int              n;
    logic [5:0][7:0] b;     // first byte in b[5]
    int              exp_n;
    logic [1:0][21:0] e;    // first message in e[1]
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    repeat (4) @(posedge clk);
    sclk = 1'b1;
    repeat (4) @(posedge clk);
    sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    repeat (6) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},   32'(valid),   32'h0);
    chk({tag, "_status"},  32'(status),  32'h0);
    chk({tag, "_d1"},      32'(d1),      32'h0);
    chk({tag, "_d2"},      32'(d2),      32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    chk({tag, "_bcd"},     32'(bcd),     32'h0);
  endtask

  initial begin
    vecs[0] = '{3, {8'h90, 8'h3C, 8'h64, 24'h0}, 1, {{8'h90, 7'h3C, 7'h64}, 22'h0}};
    vecs[1] = '{5, {8'h90, 8'h3C, 8'h64, 8'h40, 8'h00, 8'h0}, 2,
                {{8'h90, 7'h3C, 7'h64}, {8'h90, 7'h40, 7'h00}}};
    vecs[2] = '{2, {8'hC5, 8'h07, 32'h0}, 1, {{8'hC5, 7'h07, 7'h00}, 22'h0}};
    vecs[3] = '{4, {8'h80, 8'hF8, 8'h3C, 8'h00, 16'h0}, 1, {{8'h80, 7'h3C, 7'h00}, 22'h0}};
    vecs[4] = '{1, {8'h3C, 40'h0}, 0, {22'h0, 22'h0}};
    vecs[5] = '{3, {8'hF0, 8'h3C, 8'h64, 24'h0}, 0, {22'h0, 22'h0}};
    vecs[6] = '{4, {8'h90, 8'h3C, 8'hF0, 8'h40, 16'h0}, 0, {22'h0, 22'h0}};
    vecs[7] = '{3, {8'hD2, 8'h10, 8'h20, 24'h0}, 2,
                {{8'hD2, 7'h10, 7'h00}, {8'hD2, 7'h20, 7'h00}}};
    vecs[8] = '{5, {8'h90, 8'h3C, 8'h80, 8'h41, 8'h42, 8'h0}, 1,
                {{8'h80, 7'h41, 7'h42}, 22'h0}};

    #1;
    chk_reset_outputs("por");

    foreach (vecs[v]) begin
      do_reset();
      chk_reset_outputs($sformatf("v%0d_rst", v));
      ready = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[5 - i]);
      repeat (10) @(negedge clk);
      chk($sformatf("v%0d_count", v), 32'(q.size()), 32'(vecs[v].exp_n));
      for (int k = 0; k < vecs[v].exp_n; k++)
        chk($sformatf("v%0d_msg%0d", v, k),
            32'((k < q.size()) ? q[k] : 22'h3FFFFF), 32'(vecs[v].e[1 - k]));
    end

    // byte_counter_debug walk across one note-on
    do_reset();
    chk("bcd_0", 32'(bcd), 32'd0);
    send_byte(8'h90); @(negedge clk);
    chk("bcd_1", 32'(bcd), 32'd1);
    send_byte(8'h3C); @(negedge clk);
    chk("bcd_2", 32'(bcd), 32'd2);
    send_byte(8'h64); @(negedge clk);
    chk("bcd_3", 32'(bcd), 32'd0);

    // backpressure: second message dropped, overrun sticks
    do_reset();
    ready = 1'b0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    @(negedge clk);
    chk("bp_valid1", 32'(valid), 32'd1);
    chk("bp_ovr0", 32'(overrun), 32'd0);
    send_byte(8'h91); send_byte(8'h40); send_byte(8'h7F);
    @(negedge clk);
    chk("bp_valid", 32'(valid), 32'd1);
    chk("bp_msg", 32'({status, d1, d2}), 32'({8'h90, 7'h3C, 7'h64}));
    chk("bp_ovr1", 32'(overrun), 32'd1);
    ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_drop", 32'(valid), 32'd0);
    chk("bp_ovr_sticky", 32'(overrun), 32'd1);

    // partial byte discarded after idle timeout
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    repeat (4096 + 10) @(posedge clk);
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    repeat (10) @(negedge clk);
    chk("to_count", 32'(q.size()), 32'd1);
    chk("to_msg", 32'((q.size() > 0) ? q[0] : 22'h3FFFFF), 32'({8'h90, 7'h3C, 7'h64}));

    // reset mid-byte with a pending message
    do_reset();
    ready = 1'b0;
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    @(negedge clk);
    chk("mr_pending", 32'(valid), 32'd1);
    send_byte(8'h95);
    for (int i = 7; i >= 3; i--) send_bit(i == 7);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mr_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    q.delete();
    send_byte(8'h80); send_byte(8'h3C); send_byte(8'h00);
    repeat (10) @(negedge clk);
    chk("mr_count", 32'(q.size()), 32'd1);
    chk("mr_msg", 32'((q.size() > 0) ? q[0] : 22'h3FFFFF), 32'({8'h80, 7'h3C, 7'h00}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
